// File: rtl/alu_md_controller_pkg.sv
// Shared encodings for the EX-stage controller: opcodes, R-type functs,
// ALUop codes, result-source selects and the mult/div sequencer states.
package alu_md_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef logic [3:0] alu_op_t;
    localparam alu_op_t ALU_ADDU = 4'd0;
    localparam alu_op_t ALU_SUBU = 4'd1;
    localparam alu_op_t ALU_AND  = 4'd2;
    localparam alu_op_t ALU_OR   = 4'd3;
    localparam alu_op_t ALU_XOR  = 4'd4;
    localparam alu_op_t ALU_NOR  = 4'd5;
    localparam alu_op_t ALU_SLT  = 4'd6;
    localparam alu_op_t ALU_SLTU = 4'd7;
    localparam alu_op_t ALU_SLL  = 4'd8;
    localparam alu_op_t ALU_SRL  = 4'd9;
    localparam alu_op_t ALU_SRA  = 4'd10;
    localparam alu_op_t ALU_LUI  = 4'd11;
    localparam alu_op_t ALU_XXX  = 4'd15;

    localparam logic [1:0] RDSEL_ALU = 2'd0;
    localparam logic [1:0] RDSEL_HI  = 2'd1;
    localparam logic [1:0] RDSEL_LO  = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    // Functs that touch HI/LO or the sequencer and must wait for it to go idle.
    function automatic logic is_md_funct(input logic [5:0] funct);
        return (funct == F_MFHI) || (funct == F_MTHI) || (funct == F_MFLO) ||
               (funct == F_MTLO) || (funct == F_MULT) || (funct == F_MULTU) ||
               (funct == F_DIV)  || (funct == F_DIVU);
    endfunction

endpackage

// File: rtl/alu_md_controller_md_datapath.sv
// Iterative multiply (left-shifting shift-add) / restoring divide with sign fix-up.
// MD_EARLY_TERM_EN: MUL finishes once the remaining multiplier bits are all zero.
module alu_md_controller_md_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_launch,
    input  logic             i_launch_div,
    input  logic             i_launch_signed,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_step,
    input  logic             i_div,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    // DIV keeps {remainder, shifting quotient} in r_acc and the divisor in r_mcand[WIDTH-1:0].
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div_zero;

    logic [WIDTH-1:0]   w_abs_rs;
    logic [WIDTH-1:0]   w_abs_rt;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH:0]     w_sh_rem;
    logic [WIDTH:0]     w_trial;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic               w_mul_last;

    assign w_abs_rs = (i_launch_signed && i_rs[WIDTH-1]) ? -i_rs : i_rs;
    assign w_abs_rt = (i_launch_signed && i_rt[WIDTH-1]) ? -i_rt : i_rt;

    assign w_prod_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    assign w_sh_rem  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial   = w_sh_rem - {1'b0, r_mcand[WIDTH-1:0]};
    assign w_qbit    = ~w_trial[WIDTH];
    assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_sh_rem[WIDTH-1:0];
    assign w_div_nxt = {w_rem_nxt, r_acc[WIDTH-2:0], w_qbit};

`ifdef MD_EARLY_TERM_EN
    assign w_mul_last = (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_mul_last = (r_count == CW'(WIDTH - 1));
`endif

    assign o_last = i_div ? (r_count == CW'(WIDTH - 1)) : w_mul_last;

    // Results are formed from the final iteration so HI/LO load on the edge ending the last busy cycle.
    // NOTE: every signal assigned in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        w_prod_fix = r_neg_res ? -w_prod_nxt : w_prod_nxt;
        w_quo_fix  = r_neg_res ? -w_div_nxt[WIDTH-1:0] : w_div_nxt[WIDTH-1:0];
        w_rem_fix  = r_neg_rem ? -w_rem_nxt : w_rem_nxt;
        if (i_div) begin
            o_hi = w_rem_fix;
            o_lo = r_div_zero ? '1 : w_quo_fix;
        end else begin
            o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
            o_lo = w_prod_fix[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: these working registers are cleared on reset even though launch reloads them, so no X ever reaches HI/LO.
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_count    <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (i_launch) begin
            r_count    <= '0;
            r_neg_res  <= i_launch_signed & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
            r_neg_rem  <= i_launch_signed & i_rs[WIDTH-1];
            r_div_zero <= (i_rt == '0);
            r_mplier   <= w_abs_rt;
            if (i_launch_div) begin
                r_acc   <= {{WIDTH{1'b0}}, w_abs_rs};
                r_mcand <= {{WIDTH{1'b0}}, w_abs_rt};
            end else begin
                r_acc   <= '0;
                r_mcand <= {{WIDTH{1'b0}}, w_abs_rs};
            end
        end else if (i_step) begin
            r_count <= r_count + CW'(1);
            if (i_div) begin
                r_acc <= w_div_nxt;
            end else begin
                r_acc    <= w_prod_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
            end
        end
    end

endmodule

// File: rtl/alu_md_controller.sv
// EX-stage control: ALUop/rd_sel decode, mult/div FSM, HI/LO registers and interlock stall.
// Optional MD_EARLY_TERM_EN shortens MUL latency inside the datapath.
module alu_md_controller
    import alu_md_controller_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid_in,
    input  logic             i_flush,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic [WIDTH-1:0] i_rs_val,
    input  logic [WIDTH-1:0] i_rt_val,
    output logic [3:0]       o_alu_op,
    output logic [1:0]       o_rd_sel,
    output logic             o_stall,
    output logic             o_md_busy,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_r;
    logic             w_accept;
    logic             w_launch_mul;
    logic             w_launch_div;
    logic             w_launch_signed;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_step;
    logic             w_dp_last;
    logic             w_done;
    logic [WIDTH-1:0] w_dp_hi;
    logic [WIDTH-1:0] w_dp_lo;

    assign w_is_r          = (i_opcode == OP_RTYPE);
    assign w_accept        = i_valid_in & (r_state == ST_IDLE) & ~i_flush & w_is_r;
    assign w_launch_mul    = w_accept & ((i_funct == F_MULT) | (i_funct == F_MULTU));
    assign w_launch_div    = w_accept & ((i_funct == F_DIV) | (i_funct == F_DIVU));
    assign w_launch_signed = (i_funct == F_MULT) | (i_funct == F_DIV);
    assign w_mthi          = w_accept & (i_funct == F_MTHI);
    assign w_mtlo          = w_accept & (i_funct == F_MTLO);

    assign o_md_busy = (r_state == ST_MUL) | (r_state == ST_DIV);
    assign o_stall   = i_valid_in & o_md_busy & w_is_r & is_md_funct(i_funct);
    assign w_step    = o_md_busy & ~i_flush;
    assign w_done    = w_step & w_dp_last;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;

    always_comb begin
        o_alu_op = ALU_XXX;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    F_SLL, F_SLLV: o_alu_op = ALU_SLL;
                    F_SRL, F_SRLV: o_alu_op = ALU_SRL;
                    F_SRA, F_SRAV: o_alu_op = ALU_SRA;
                    F_ADDU:        o_alu_op = ALU_ADDU;
                    F_SUBU:        o_alu_op = ALU_SUBU;
                    F_AND:         o_alu_op = ALU_AND;
                    F_OR:          o_alu_op = ALU_OR;
                    F_XOR:         o_alu_op = ALU_XOR;
                    F_NOR:         o_alu_op = ALU_NOR;
                    F_SLT:         o_alu_op = ALU_SLT;
                    F_SLTU:        o_alu_op = ALU_SLTU;
                    default:       o_alu_op = ALU_XXX;
                endcase
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW, OP_ADDIU: o_alu_op = ALU_ADDU;
            OP_LUI:   o_alu_op = ALU_LUI;
            OP_SLTI:  o_alu_op = ALU_SLT;
            OP_SLTIU: o_alu_op = ALU_SLTU;
            OP_ANDI:  o_alu_op = ALU_AND;
            OP_ORI:   o_alu_op = ALU_OR;
            OP_XORI:  o_alu_op = ALU_XOR;
            default:  o_alu_op = ALU_XXX;
        endcase
    end

    always_comb begin
        o_rd_sel = RDSEL_ALU;
        if (w_is_r && i_funct == F_MFHI) o_rd_sel = RDSEL_HI;
        if (w_is_r && i_funct == F_MFLO) o_rd_sel = RDSEL_LO;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_launch_mul)      r_state <= ST_MUL;
                    else if (w_launch_div) r_state <= ST_DIV;
                end
                ST_MUL, ST_DIV: begin
                    if (i_flush || w_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sequencer results and MTHI/MTLO are mutually exclusive: one needs busy, the other idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_dp_hi;
            r_lo <= w_dp_lo;
        end else begin
            if (w_mthi) r_hi <= i_rs_val;
            if (w_mtlo) r_lo <= i_rs_val;
        end
    end

    alu_md_controller_md_datapath #(
        .WIDTH(WIDTH)
    ) u_md_datapath (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_launch        (w_launch_mul | w_launch_div),
        .i_launch_div    (w_launch_div),
        .i_launch_signed (w_launch_signed),
        .i_rs            (i_rs_val),
        .i_rt            (i_rt_val),
        .i_step          (w_step),
        .i_div           (r_state == ST_DIV),
        .o_last          (w_dp_last),
        .o_hi            (w_dp_hi),
        .o_lo            (w_dp_lo)
    );

endmodule
